// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-address generator with redirect priority, window checking and a
// sticky fault state that only a synchronous clear leaves.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter int unsigned TEXT_WORDS = 256
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc,
  output logic [31:0] retired
);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  // One extra bit so a window ending exactly at 2^32 still compares correctly.
  localparam logic [32:0] WinEnd = {1'b0, RESET_PC} + (33'(TEXT_WORDS) << 2);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [1:0]  fault_cause_q, fault_cause_d;

  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        misaligned;
  logic        out_of_window;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg) begin
      next_pc = reg_target;
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  assign misaligned    = (next_pc[1:0] != 2'b00);
  assign out_of_window = (next_pc < RESET_PC) || ({1'b0, next_pc} >= WinEnd);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    retired_d     = retired_q;
    fault_pc_d    = fault_pc_q;
    fault_cause_d = fault_cause_q;
    unique case (state_q)
      StRun: begin
        if (!stall) begin
          if (!misaligned && !out_of_window) begin
            pc_d      = next_pc;
            retired_d = retired_q + 32'd1;
          end else begin
            state_d       = StFault;
            fault_pc_d    = next_pc;
            fault_cause_d = {out_of_window, misaligned};
          end
        end
      end
      StFault: ;
      default: state_d = StFault;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      retired_q     <= 32'd0;
      fault_pc_q    <= 32'd0;
      fault_cause_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      retired_q     <= retired_d;
      fault_pc_q    <= fault_pc_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  assign pc          = pc_q;
  assign fault       = (state_q == StFault);
  assign fault_cause = fault_cause_q;
  assign fault_pc    = fault_pc_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with fixed expectations, then random redirects
// checked against an arithmetic reference model that tracks every clock edge.
module tb_pc_fetch_unit;

  localparam logic [31:0] Rst = 32'h00400000;
  localparam int unsigned Tw  = 256;

  logic        clock = 1'b0;
  logic        clear, stall, branch_taken, jump, jump_reg;
  logic [15:0] branch_imm;
  logic [25:0] jump_target;
  logic [31:0] reg_target;
  logic [31:0] pc, pc_plus4, fault_pc, retired;
  logic        fault;
  logic [1:0]  fault_cause;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [31:0] m_pc, m_fpc, m_ret;
  logic [1:0]  m_cause;
  logic        m_fault;

  always #5 clock = ~clock;

  pc_fetch_unit #(
    .RESET_PC  (Rst),
    .TEXT_WORDS(Tw)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .stall       (stall),
    .branch_taken(branch_taken),
    .branch_imm  (branch_imm),
    .jump        (jump),
    .jump_target (jump_target),
    .jump_reg    (jump_reg),
    .reg_target  (reg_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_pc    (fault_pc),
    .retired     (retired)
  );

  task automatic idle_inputs();
    clear = 0; stall = 0; branch_taken = 0; branch_imm = 0;
    jump = 0; jump_target = 0; jump_reg = 0; reg_target = 0;
  endtask

  task automatic model_update();
    longint p4, nxt, off, lo, hi;
    bit mis, oow;
    if (clear) begin
      m_pc = Rst; m_ret = 0; m_fault = 0; m_cause = 0; m_fpc = 0;
    end else if (!m_fault && !stall) begin
      p4  = (longint'(m_pc) + 4) & 64'hFFFF_FFFF;
      off = longint'($signed(branch_imm));
      if (jump_reg)          nxt = longint'(reg_target);
      else if (jump)         nxt = (p4 & 64'hF000_0000) | (longint'(jump_target) * 4);
      else if (branch_taken) nxt = (p4 + off * 4) & 64'hFFFF_FFFF;
      else                   nxt = p4;
      lo  = longint'(Rst);
      hi  = lo + 4 * longint'(Tw);
      mis = (nxt % 4) != 0;
      oow = (nxt < lo) || (nxt >= hi);
      if (!mis && !oow) begin
        m_pc  = nxt[31:0];
        m_ret = m_ret + 1;
      end else begin
        m_fault = 1; m_cause = {oow, mis}; m_fpc = nxt[31:0];
      end
    end
  endtask

  // Apply current inputs across one rising edge and settle just after it.
  task automatic step();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    idle_inputs(); clear = 1; step();
    idle_inputs(); jump_reg = 1; reg_target = addr; step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs(); clear = 1; branch_taken = 1; branch_imm = 16'h0040; step();
    idle_inputs();
    checks++; if (pc !== Rst) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, Rst); end
    checks++; if (pc_plus4 !== Rst + 4) begin fails++; $display("FAIL reset_pc4: got %h want %h", pc_plus4, Rst + 4); end
    checks++; if (retired !== 0) begin fails++; $display("FAIL reset_retired: got %0d want 0", retired); end
    checks++; if (fault !== 0 || fault_cause !== 0 || fault_pc !== 0) begin
      fails++; $display("FAIL reset_fault: got %b/%b/%h want 0/00/0", fault, fault_cause, fault_pc);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4] = '{32'h00400000, 32'h00400004, 32'h00400008, 32'h0040000C};
    idle_inputs(); clear = 1; step(); idle_inputs();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pc !== exp_pc[i]) begin fails++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, exp_pc[i]); end
      if (i < 3) step();
    end
    checks++; if (retired !== 3) begin fails++; $display("FAIL seq_retired: got %0d want 3", retired); end
  endtask

  task automatic test_priority();
    goto_pc(32'h00400010);
    branch_taken = 1; branch_imm = 16'hFFFC; jump_reg = 1; reg_target = 32'h00400100;
    jump = 1; jump_target = 26'h0100040;
    step(); idle_inputs();
    checks++; if (pc !== 32'h00400100) begin fails++; $display("FAIL prio_pc: got %h want 00400100", pc); end
    checks++; if (retired !== 2) begin fails++; $display("FAIL prio_retired: got %0d want 2", retired); end
    jump = 1; jump_target = 26'h0100050; branch_taken = 1; branch_imm = 16'h0010; step(); idle_inputs();
    checks++; if (pc !== 32'h00400140) begin fails++; $display("FAIL prio_jump: got %h want 00400140", pc); end
  endtask

  task automatic test_backward_branch();
    goto_pc(32'h00400018);
    branch_taken = 1; branch_imm = 16'hFFF9; step(); idle_inputs();
    checks++; if (pc !== 32'h00400000) begin fails++; $display("FAIL back_pc: got %h want 00400000", pc); end
  endtask

  task automatic test_self_loop();
    goto_pc(32'h00400080);
    branch_taken = 1; branch_imm = 16'hFFFF; step(); idle_inputs();
    checks++; if (pc !== 32'h00400080 || retired !== 2) begin
      fails++; $display("FAIL self_loop: got pc %h ret %0d want 00400080 2", pc, retired);
    end
  endtask

  task automatic test_stall();
    goto_pc(32'h00400020);
    for (int i = 0; i < 2; i++) begin
      stall = 1; jump = 1; jump_target = 26'h0100080; step();
      checks++; if (pc !== 32'h00400020 || retired !== 1) begin
        fails++; $display("FAIL stall_hold%0d: got pc %h ret %0d want 00400020 1", i, pc, retired);
      end
    end
    idle_inputs(); step();
    checks++; if (pc !== 32'h00400024 || retired !== 2) begin
      fails++; $display("FAIL stall_release: got pc %h ret %0d want 00400024 2", pc, retired);
    end
  endtask

  task automatic test_fault();
    idle_inputs(); clear = 1; step(); idle_inputs();
    jump_reg = 1; reg_target = 32'h00400002; step(); idle_inputs();
    checks++; if (fault !== 1 || fault_cause !== 2'b01 || fault_pc !== 32'h00400002) begin
      fails++; $display("FAIL fault_enter: got %b/%b/%h want 1/01/00400002", fault, fault_cause, fault_pc);
    end
    checks++; if (pc !== Rst || retired !== 0) begin
      fails++; $display("FAIL fault_pc_hold: got pc %h ret %0d want %h 0", pc, retired, Rst);
    end
    for (int i = 0; i < 3; i++) begin
      stall = 1'($urandom); jump = 1'($urandom); jump_reg = 1'($urandom); branch_taken = 1;
      reg_target = Rst + 32'h40; jump_target = 26'h0100010; branch_imm = 16'h0004;
      step();
      checks++;
      if (fault !== 1 || fault_cause !== 2'b01 || fault_pc !== 32'h00400002 || pc !== Rst || retired !== 0) begin
        fails++; $display("FAIL fault_ignore%0d: got %b/%b/%h pc %h ret %0d", i, fault, fault_cause, fault_pc, pc, retired);
      end
    end
    idle_inputs(); clear = 1; step(); idle_inputs();
    checks++; if (pc !== Rst || fault !== 0 || fault_cause !== 0 || fault_pc !== 0) begin
      fails++; $display("FAIL fault_clear: got pc %h fault %b cause %b fpc %h", pc, fault, fault_cause, fault_pc);
    end
    step();
    checks++; if (pc !== 32'h00400004) begin fails++; $display("FAIL fault_resume: got %h want 00400004", pc); end
  endtask

  task automatic test_clear_mid_stall();
    goto_pc(32'h00400040);
    stall = 1; clear = 1; jump_reg = 1; reg_target = 32'h00400100; step();
    idle_inputs();
    checks++; if (pc !== Rst || retired !== 0) begin
      fails++; $display("FAIL clear_stall: got pc %h ret %0d want %h 0", pc, retired, Rst);
    end
    step();
    checks++; if (pc !== 32'h00400004 || retired !== 1) begin
      fails++; $display("FAIL clear_stall_adv: got pc %h ret %0d want 00400004 1", pc, retired);
    end
  endtask

  task automatic test_end_of_window();
    goto_pc(32'h004003FC);
    checks++; if (pc !== 32'h004003FC || fault !== 0) begin
      fails++; $display("FAIL eow_last: got pc %h fault %b want 004003FC 0", pc, fault);
    end
    step();
    checks++; if (fault !== 1 || fault_cause !== 2'b10 || fault_pc !== 32'h00400400 || pc !== 32'h004003FC) begin
      fails++; $display("FAIL eow_fault: got %b/%b/%h pc %h", fault, fault_cause, fault_pc, pc);
    end
    idle_inputs(); jump_reg = 0; clear = 1; step(); idle_inputs();
    jump_reg = 1; reg_target = 32'h003FFFFE; step(); idle_inputs();
    checks++; if (fault !== 1 || fault_cause !== 2'b11 || fault_pc !== 32'h003FFFFE) begin
      fails++; $display("FAIL both_cause: got %b/%b/%h want 1/11/003FFFFE", fault, fault_cause, fault_pc);
    end
  endtask

  task automatic test_random();
    idle_inputs(); clear = 1; step(); idle_inputs();
    for (int i = 0; i < 800; i++) begin
      clear        = ($urandom_range(0, 99) < 4);
      stall        = ($urandom_range(0, 3) == 0);
      jump_reg     = ($urandom_range(0, 7) == 0);
      jump         = ($urandom_range(0, 5) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      reg_target   = ($urandom_range(0, 9) == 0) ? $urandom : Rst + $urandom_range(0, 1100);
      jump_target  = 26'((Rst >> 2) + $urandom_range(0, 300));
      branch_imm   = 16'(int'($urandom_range(0, 600)) - 300);
      step();
      checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || retired !== m_ret || fault !== m_fault ||
          fault_cause !== m_cause || fault_pc !== m_fpc) begin
        fails++;
        $display("FAIL rand%0d: got pc %h p4 %h ret %0d f %b c %b fpc %h want pc %h ret %0d f %b c %b fpc %h",
                 i, pc, pc_plus4, retired, fault, fault_cause, fault_pc,
                 m_pc, m_ret, m_fault, m_cause, m_fpc);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pc = Rst; m_ret = 0; m_fault = 0; m_cause = 0; m_fpc = 0;
    @(negedge clock);
    test_reset();
    test_sequential();
    test_priority();
    test_backward_branch();
    test_self_loop();
    test_stall();
    test_fault();
    test_clear_mid_stall();
    test_end_of_window();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00400000, meaning the first fetch address after clear.
REQ-002 SHALL have parameter TEXT_WORDS, default 256, meaning the number of 32-bit words in the legal fetch window starting at RESET_PC.
REQ-003 SHALL have port clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear  input  1  meaning a synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  meaning hold the current PC this cycle.
REQ-006 SHALL have port branch_taken  input  1  meaning take the PC-relative branch.
REQ-007 SHALL have port branch_imm  input  16  meaning the signed word offset of the branch.
REQ-008 SHALL have port jump  input  1  meaning take the absolute jump.
REQ-009 SHALL have port jump_target  input  26  meaning the jump word index (the J-format field).
REQ-010 SHALL have port jump_reg  input  1  meaning take the register jump.
REQ-011 SHALL have port reg_target  input  32  meaning the register jump address.
REQ-012 SHALL have port pc  output  32  meaning the current fetch address, which drives the instruction memory address input.
REQ-013 SHALL have port pc_plus4  output  32  meaning pc+4, combinational from pc.
REQ-014 SHALL have port fault  output  1  meaning the unit is in FAULT state.
REQ-015 SHALL have port fault_cause  output  2  meaning 00 none, 01 misaligned, 10 out of window, 11 both.
REQ-016 SHALL have port fault_pc  output  32  meaning the rejected next-PC value.
REQ-017 SHALL have port retired  output  32  meaning the count of PC advances since clear.

Function
REQ-018 SHALL implement two states: RUN and FAULT.
REQ-019 In RUN with stall=0, SHALL compute next_pc by priority: jump_reg -> reg_target; else jump -> {pc_plus4[31:28], jump_target, 2'b00}; else branch_taken -> pc_plus4 + (sign-extended branch_imm << 2); else pc_plus4.
REQ-020 SHALL perform all address arithmetic modulo 2^32, with no carry out.
REQ-021 SHALL treat next_pc as legal iff next_pc[1:0]==0 and RESET_PC <= next_pc < RESET_PC + 4*TEXT_WORDS, using an unsigned compare.
REQ-022 On a legal next_pc in RUN with stall=0, SHALL load pc<=next_pc and retired<=retired+1 at the next edge, giving a latency of one cycle.
REQ-023 On an illegal next_pc in RUN with stall=0, SHALL hold pc, hold retired, set fault_pc<=next_pc, set fault_cause per REQ-015, and enter FAULT.
REQ-024 With stall=1 in RUN, SHALL hold pc, retired and state; redirect inputs in that cycle are discarded, not queued.
REQ-025 In FAULT, SHALL ignore all inputs except clear, and SHALL hold pc, retired, fault_pc and fault_cause.
REQ-026 SHALL drive fault=1 exactly when in FAULT.
REQ-027 SHALL let retired wrap from 32'hFFFFFFFF to 0 without a flag.
REQ-028 SHALL treat a self-loop (next_pc==pc) as a legal advance that increments retired.
REQ-029 SHALL treat the last legal word RESET_PC+4*(TEXT_WORDS-1) as fetchable, and SHALL fault when sequential fetch runs past it.

Reset
REQ-030 On clock edge with clear=1, SHALL set pc=RESET_PC, retired=0, fault_pc=0, fault_cause=00 and state=RUN, overriding every other input.
REQ-031 SHALL apply clear taken mid-stall or in FAULT identically; the first advance SHALL occur on the edge after clear deasserts.

Verification
REQ-032 SHALL cover sequential fetch: clear, then 3 idle cycles -> pc 00400000, 00400004, 00400008, 0040000C; retired=3.
REQ-033 SHALL cover priority: at pc=00400010, assert branch_taken with imm=16'hFFFC and jump_reg with reg_target=00400100 together -> pc=00400100.
REQ-034 SHALL cover backward branch: pc=00400018, imm=16'hFFF9 -> pc=00400000.
REQ-035 SHALL cover stall: assert stall plus jump for 2 cycles at pc=00400020 -> pc stays 00400020 and retired is unchanged; then release with no jump -> 00400024.
REQ-036 SHALL cover fault: jump_reg with reg_target=00400002 -> fault=1, cause=01, fault_pc=00400002, pc unchanged; inputs ignored for 3 cycles; clear -> pc=00400000, fault=0.
REQ-037 SHALL cover end of window: sequential from 004003FC -> fault=1, cause=10, fault_pc=00400400.
